// File: rtl/z80_bus_target_if.sv
// Z80 CPU-side bus bundle for z80_bus_target: address/data/strobes from the CPU,
// read data, wait and interrupt lines back from the target.
interface z80_bus_target_if;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        m1_n;
  logic        rfsh_n;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        wait_n;
  logic        int_n;

  modport master (
    output a, d_in, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
    input  d_out, d_oe, wait_n, int_n
  );

  modport slave (
    input  a, d_in, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n,
    output d_out, d_oe, wait_n, int_n
  );
endinterface

// File: rtl/z80_bus_target.sv
// Z80 bus target: scratch RAM window, one control/status I/O port and IM2 interrupt
// acknowledge. Define Z80_TARGET_WAIT_EN to build the wait-state generator.
module z80_bus_target #(
  parameter logic [15:0] MEM_BASE      = 16'h8000,
  parameter int          MEM_SIZE_LOG2 = 6,
  parameter logic [7:0]  IO_PORT       = 8'h10,
  parameter int          WAIT_STATES   = 2,
  parameter logic [7:0]  IM2_VECTOR    = 8'hE0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             irq_i,
  z80_bus_target_if.slave  bus
);

  localparam int          MEM_DEPTH = 2 ** MEM_SIZE_LOG2;
  localparam logic [16:0] MEM_LO    = {1'b0, MEM_BASE};
  localparam logic [16:0] MEM_HI    = MEM_LO + 17'(MEM_DEPTH);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_wait_states_range
    $error("z80_bus_target: WAIT_STATES must be within 0..15");
  end

`ifdef Z80_TARGET_WAIT_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);
`else
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HOLD} state_t;
`endif

  typedef enum logic [1:0] {K_MEM, K_IO, K_INTA} kind_t;

  state_t     state_q, state_d;
  kind_t      kind_q, kind_d;
  logic       is_rd_q, is_rd_d;
  logic [7:0] d_out_q, d_out_d;
  logic       d_oe_q, d_oe_d;
  logic       pending_q, pending_d;
  logic       ie_q, ie_d;
  logic       int_n_q;
  logic       clr_pending;
  logic       ram_we;
  logic [7:0] ram [MEM_DEPTH];

`ifdef Z80_TARGET_WAIT_EN
  logic       wait_n_q, wait_n_d;
  logic [3:0] wcnt_q, wcnt_d;
`endif

  logic                     mem_hit, io_hit, inta_hit, foreign, strobe_live;
  logic [MEM_SIZE_LOG2-1:0] ram_idx;
  logic [7:0]               status_byte;

  assign ram_idx     = bus.a[MEM_SIZE_LOG2-1:0];
  assign status_byte = {pending_q, 6'b0, ie_q};

  // Refresh cycles never match: rfsh_n gates both the memory decode and the foreign-cycle check.
  always_comb begin
    mem_hit  = !bus.mreq_n && bus.rfsh_n && (!bus.rd_n || !bus.wr_n) &&
               ({1'b0, bus.a} >= MEM_LO) && ({1'b0, bus.a} < MEM_HI);
    io_hit   = !bus.iorq_n && bus.m1_n && (!bus.rd_n || !bus.wr_n) &&
               (bus.a[7:0] == IO_PORT);
    inta_hit = !bus.m1_n && !bus.iorq_n;
    foreign  = ((!bus.mreq_n && bus.rfsh_n) || !bus.iorq_n) && (!bus.rd_n || !bus.wr_n);
    strobe_live = (kind_q == K_MEM) ? !bus.mreq_n : !bus.iorq_n;
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    is_rd_d     = is_rd_q;
    d_out_d     = d_out_q;
    d_oe_d      = d_oe_q;
    ie_d        = ie_q;
    clr_pending = 1'b0;
    ram_we      = 1'b0;
`ifdef Z80_TARGET_WAIT_EN
    wait_n_d    = wait_n_q;
    wcnt_d      = wcnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (inta_hit || io_hit || mem_hit) begin
          kind_d  = inta_hit ? K_INTA : (io_hit ? K_IO : K_MEM);
          is_rd_d = inta_hit || !bus.rd_n;
`ifdef Z80_TARGET_WAIT_EN
          if (WAIT_STATES > 0) begin
            state_d  = S_WAIT;
            wait_n_d = 1'b0;
            wcnt_d   = 4'd0;
          end else begin
            state_d     = S_ACCESS;
            clr_pending = inta_hit;
          end
`else
          state_d     = S_ACCESS;
          clr_pending = inta_hit;
`endif
        end else if (foreign) begin
          state_d = S_HOLD;
        end
      end

`ifdef Z80_TARGET_WAIT_EN
      S_WAIT: begin
        if (!strobe_live) begin
          state_d  = S_IDLE;
          wait_n_d = 1'b1;
          wcnt_d   = 4'd0;
        end else if (wcnt_q == WS_LAST) begin
          state_d     = S_ACCESS;
          wait_n_d    = 1'b1;
          wcnt_d      = 4'd0;
          clr_pending = (kind_q == K_INTA);
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
`endif

      // Writes linger here until wr_n falls, since the CPU drops wr_n a cycle after mreq_n.
      S_ACCESS: begin
        if (!strobe_live) begin
          state_d = S_IDLE;
          d_oe_d  = 1'b0;
        end else if (is_rd_q) begin
          case (kind_q)
            K_MEM:   d_out_d = ram[ram_idx];
            K_IO:    d_out_d = status_byte;
            default: d_out_d = IM2_VECTOR;
          endcase
          d_oe_d  = 1'b1;
          state_d = S_HOLD;
        end else if (!bus.wr_n) begin
          if (kind_q == K_MEM) begin
            ram_we = 1'b1;
          end else begin
            ie_d        = bus.d_in[0];
            clr_pending = bus.d_in[7];
          end
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (bus.mreq_n && bus.iorq_n) begin
          state_d = S_IDLE;
          d_oe_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        d_oe_d  = 1'b0;
      end
    endcase

    pending_d = irq_i ? 1'b1 : (clr_pending ? 1'b0 : pending_q);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      kind_q    <= K_MEM;
      is_rd_q   <= 1'b0;
      d_out_q   <= 8'h00;
      d_oe_q    <= 1'b0;
      pending_q <= 1'b0;
      ie_q      <= 1'b0;
      int_n_q   <= 1'b1;
`ifdef Z80_TARGET_WAIT_EN
      wait_n_q  <= 1'b1;
      wcnt_q    <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      is_rd_q   <= is_rd_d;
      d_out_q   <= d_out_d;
      d_oe_q    <= d_oe_d;
      pending_q <= pending_d;
      ie_q      <= ie_d;
      int_n_q   <= ~(pending_d & ie_d);
`ifdef Z80_TARGET_WAIT_EN
      wait_n_q  <= wait_n_d;
      wcnt_q    <= wcnt_d;
`endif
    end
  end

  // RAM contents survive reset; a reset edge only blocks the write in flight.
  always_ff @(posedge wb_clk_i) begin
    if (ram_we && !wb_rst_i) begin
      ram[ram_idx] <= bus.d_in;
    end
  end

  assign bus.d_out = d_out_q;
  assign bus.d_oe  = d_oe_q;
  assign bus.int_n = int_n_q;
`ifdef Z80_TARGET_WAIT_EN
  assign bus.wait_n = wait_n_q;
`else
  assign bus.wait_n = 1'b1;
`endif

endmodule

// File: tb/tb_z80_bus_target.sv
// Randomised scoreboard bench for z80_bus_target: directed bus scenarios followed by
// random memory, I/O, interrupt and undecoded cycles checked against a byte-level model.
module tb_z80_bus_target;

  localparam logic [15:0] MEM_BASE    = 16'h8000;
  localparam int          MEM_DEPTH   = 64;
  localparam logic [7:0]  IO_PORT     = 8'h10;
  localparam int          WAIT_STATES = 2;
  localparam logic [7:0]  IM2_VECTOR  = 8'hE0;
`ifdef Z80_TARGET_WAIT_EN
  localparam int WS_EFF = WAIT_STATES;
`else
  localparam int WS_EFF = 0;
`endif
  localparam int HOLD_WINDOW = WS_EFF + 6;

  typedef enum int {OP_MEM_RD, OP_MEM_WR, OP_IO_RD, OP_IO_WR, OP_INTA, OP_REFRESH} op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq = 1'b0;

  z80_bus_target_if bus();

  z80_bus_target dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .irq_i    (irq),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_mem     [MEM_DEPTH];
  bit         m_written [MEM_DEPTH];
  bit         m_ie      = 1'b0;
  bit         m_pending = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_total++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic bit inWindow(input logic [15:0] addr);
    return (int'(addr) >= int'(MEM_BASE)) && (int'(addr) < int'(MEM_BASE) + MEM_DEPTH);
  endfunction

  // Monitor: every rising d_oe presents one read byte, matched in order against the scoreboard.
  initial begin
    logic oe_prev;
    logic [7:0] want;
    oe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.d_oe && !oe_prev) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL d_out: got %02h with no read expected", bus.d_out);
        end else begin
          want = exp_q.pop_front();
          if (bus.d_out !== want) begin
            n_bad++;
            $display("[TB] FAIL d_out: got %02h expected %02h", bus.d_out, want);
          end
        end
      end
      oe_prev = bus.d_oe;
    end
  end

  task automatic idleBus();
    bus.mreq_n = 1'b1;
    bus.iorq_n = 1'b1;
    bus.rd_n   = 1'b1;
    bus.wr_n   = 1'b1;
    bus.m1_n   = 1'b1;
    bus.rfsh_n = 1'b1;
  endtask

  // One complete CPU bus cycle; irq_same_edge raises irq_i exactly on the control-write edge.
  task automatic applyStimulus(input op_t op, input logic [15:0] addr, input logic [7:0] data,
                               input bit irq_same_edge);
    bit   hit, rd, oe_drop;
    int   wait_low, first_oe, idx;
    logic [7:0] expect_byte;
    idx = int'(addr[5:0]);
    case (op)
      OP_MEM_RD: begin hit = inWindow(addr); rd = 1'b1; end
      OP_MEM_WR: begin hit = inWindow(addr); rd = 1'b0; end
      OP_IO_RD:  begin hit = (addr[7:0] == IO_PORT); rd = 1'b1; end
      OP_IO_WR:  begin hit = (addr[7:0] == IO_PORT); rd = 1'b0; end
      OP_INTA:   begin hit = 1'b1; rd = 1'b1; end
      default:   begin hit = 1'b0; rd = 1'b1; end
    endcase
    if (hit && rd) begin
      case (op)
        OP_MEM_RD: expect_byte = m_mem[idx];
        OP_IO_RD:  expect_byte = {m_pending, 6'b0, m_ie};
        default:   expect_byte = IM2_VECTOR;
      endcase
      exp_q.push_back(expect_byte);
    end
    wait_low = 0;
    first_oe = -1;
    oe_drop  = 1'b0;
    @(negedge clk);
    bus.a    = addr;
    bus.d_in = data;
    case (op)
      OP_MEM_RD:  begin bus.mreq_n = 1'b0; bus.rd_n = 1'b0; end
      OP_MEM_WR:  bus.mreq_n = 1'b0;
      OP_IO_RD:   begin bus.iorq_n = 1'b0; bus.rd_n = 1'b0; end
      OP_IO_WR:   begin bus.iorq_n = 1'b0; bus.wr_n = 1'b0; end
      OP_INTA:    begin bus.m1_n = 1'b0; bus.iorq_n = 1'b0; end
      default:    begin bus.mreq_n = 1'b0; bus.rfsh_n = 1'b0; bus.rd_n = 1'b0; end
    endcase
    for (int i = 1; i <= HOLD_WINDOW; i++) begin
      @(negedge clk);
      if (!bus.wait_n) wait_low++;
      if (bus.d_oe) begin
        if (first_oe < 0) first_oe = i;
      end else if (first_oe >= 0) begin
        oe_drop = 1'b1;
      end
      if (op == OP_MEM_WR && i == 1) bus.wr_n = 1'b0;
      if (irq_same_edge) begin
        if (i == WS_EFF + 1) irq = 1'b1;
        else if (i == WS_EFF + 2) irq = 1'b0;
      end
    end
    idleBus();
    @(negedge clk);
    checkOutput("oe_release", int'(bus.d_oe), 0);
    if (hit) begin
      case (op)
        OP_MEM_WR: begin m_mem[idx] = data; m_written[idx] = 1'b1; end
        OP_IO_WR: begin
          m_ie = data[0];
          if (data[7]) m_pending = 1'b0;
          if (irq_same_edge) m_pending = 1'b1;
        end
        OP_INTA:   m_pending = 1'b0;
        default:   ;
      endcase
    end
    checkOutput("wait_len", wait_low, hit ? WS_EFF : 0);
    if (hit && rd) begin
      checkOutput("oe_latency", first_oe, WS_EFF + 2);
      checkOutput("oe_hold", int'(oe_drop), 0);
    end else begin
      checkOutput("oe_quiet", first_oe, -1);
    end
    checkOutput("int_n", int'(bus.int_n), int'(!(m_pending && m_ie)));
  endtask

  task automatic pulseIrq();
    @(negedge clk);
    irq = 1'b1;
    @(negedge clk);
    irq = 1'b0;
    m_pending = 1'b1;
    checkOutput("int_n_after_irq", int'(bus.int_n), int'(!(m_pending && m_ie)));
  endtask

  // Reset lands while a write to the RAM window is in flight; nothing may be stored.
  task automatic resetMidCycle(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.a = addr;
    bus.d_in = data;
    bus.mreq_n = 1'b0;
    bus.wr_n = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_wait_n", int'(bus.wait_n), 1);
    checkOutput("rst_d_oe", int'(bus.d_oe), 0);
    idleBus();
    rst = 1'b0;
    m_ie = 1'b0;
    m_pending = 1'b0;
    @(negedge clk);
    checkOutput("rst_int_n", int'(bus.int_n), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    op_t        op;
    logic [15:0] addr;
    logic [7:0]  data;
    int          pick, idx;
    idleBus();
    bus.a = 16'h0000;
    bus.d_in = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_d_out", int'(bus.d_out), 0);
    checkOutput("reset_d_oe", int'(bus.d_oe), 0);
    checkOutput("reset_wait_n", int'(bus.wait_n), 1);
    checkOutput("reset_int_n", int'(bus.int_n), 1);
    rst = 1'b0;

    applyStimulus(OP_MEM_WR, 16'h8003, 8'h5A, 1'b0);
    applyStimulus(OP_MEM_RD, 16'h8003, 8'h00, 1'b0);
    applyStimulus(OP_MEM_RD, 16'h4000, 8'h00, 1'b0);
    applyStimulus(OP_REFRESH, 16'h8000, 8'h00, 1'b0);
    applyStimulus(OP_MEM_RD, 16'h8040, 8'h00, 1'b0);
    applyStimulus(OP_MEM_WR, 16'h803F, 8'hA7, 1'b0);
    applyStimulus(OP_MEM_RD, 16'h803F, 8'h00, 1'b0);
    applyStimulus(OP_IO_WR, 16'h0010, 8'h01, 1'b0);
    pulseIrq();
    applyStimulus(OP_INTA, 16'h00FF, 8'h00, 1'b0);
    applyStimulus(OP_IO_WR, 16'h0010, 8'h81, 1'b1);
    applyStimulus(OP_IO_RD, 16'h0010, 8'h00, 1'b0);
    applyStimulus(OP_MEM_WR, 16'h8010, 8'h3C, 1'b0);
    resetMidCycle(16'h8010, 8'hC3);
    applyStimulus(OP_MEM_RD, 16'h8010, 8'h00, 1'b0);
    applyStimulus(OP_IO_RD, 16'h0010, 8'h00, 1'b0);

    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 9);
      data = 8'($urandom);
      addr = MEM_BASE + 16'($urandom_range(0, MEM_DEPTH - 1));
      case (pick)
        0, 1: applyStimulus(OP_MEM_WR, addr, data, 1'b0);
        2, 3: begin
          idx = int'(addr[5:0]);
          if (m_written[idx]) applyStimulus(OP_MEM_RD, addr, 8'h00, 1'b0);
          else applyStimulus(OP_MEM_WR, addr, data, 1'b0);
        end
        4: applyStimulus(OP_IO_WR, {8'($urandom), IO_PORT}, data, ($urandom_range(0, 2) == 0));
        5: applyStimulus(OP_IO_RD, {8'($urandom), IO_PORT}, 8'h00, 1'b0);
        6: pulseIrq();
        7: applyStimulus(OP_INTA, 16'($urandom), 8'h00, 1'b0);
        8: begin
          addr = 16'($urandom_range(0, 16'h7FFF));
          op = ($urandom_range(0, 1) == 0) ? OP_MEM_RD : OP_REFRESH;
          applyStimulus(op, addr, 8'h00, 1'b0);
        end
        default: begin
          addr = {8'($urandom), 8'($urandom_range(8'h11, 8'hFF))};
          op = ($urandom_range(0, 1) == 0) ? OP_IO_RD : OP_IO_WR;
          applyStimulus(op, addr, data, 1'b0);
        end
      endcase
    end

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
